// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command slave.
// Contents: GPU-side FSM state type, host address map and the opcode word index.
package gpu_pkg;

  typedef enum logic [1:0] {
    G_IDLE    = 2'd0,
    G_BUSY    = 2'd1,
    G_RELEASE = 2'd2
  } GpuFsmType;

  localparam logic [1:0] ADDR_OP1    = 2'd0;
  localparam logic [1:0] ADDR_OP2    = 2'd1;
  localparam logic [1:0] ADDR_OP3    = 2'd2;
  localparam logic [1:0] ADDR_OPCODE = 2'd3;

  // Word index of the opcode within a command; reads saturate here.
  localparam logic [1:0] WORD_IDX_OPCODE = 2'd3;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO, one entry per complete command.
// Ports: clk, n_reset (async low), push/din, pop/dout (head, combinational),
//        full, empty, count (one bit wider than the pointers).
// A push into a full FIFO is accepted when a pop happens in the same cycle;
// the head is read before the edge, so reusing its slot is safe.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_slave.sv
// Host-facing command buffer in front of the GPU control unit.
// Host side (Avalon-MM): avs_address/avs_write/avs_writedata stage operands
//   (addr 0..2) and commit a command (addr 3); avs_waitrequest stalls a commit
//   while the FIFO is full; avs_read/avs_readdata return status.
// GPU side: busy flags a head command, read/rd_data/rd_valid stream its words
//   (op1, op2, op3, opcode), busy_reset retires it.
// Build option: define GPU_CMD_STATUS_EN to build the status register
//   {count, full, empty, busy}; otherwise avs_readdata is tied to 0.
module gpu_cmd_slave
  import gpu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              busy,
  input  logic              read,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              busy_reset
);

  localparam int CW = $clog2(CMD_DEPTH) + 1;

  logic [DATA_W-1:0]   op1, op2, op3;
  logic [4*DATA_W-1:0] head;
  logic [CW-1:0]       count;
  logic                full, empty, push, pop, commit;
  logic [1:0]          idx;
  logic [DATA_W-1:0]   word;
  GpuFsmType           state;

  // Pop is tied to the release state, so a stalled commit is let through
  // in exactly the cycle the head slot is freed.
  assign commit          = avs_write && (avs_address == ADDR_OPCODE);
  assign pop             = (state == G_RELEASE);
  assign avs_waitrequest = commit && full && !pop;
  assign push            = commit && !avs_waitrequest;
  assign busy            = (state == G_BUSY);

  gpu_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(4*DATA_W)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .din     ({op1, op2, op3, avs_writedata}),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Operand staging; deliberately not cleared by a commit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      op1 <= '0;
      op2 <= '0;
      op3 <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_OP1: op1 <= avs_writedata;
        ADDR_OP2: op2 <= avs_writedata;
        ADDR_OP3: op3 <= avs_writedata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    word = head[DATA_W-1:0];
    case (idx)
      2'd0:    word = head[4*DATA_W-1:3*DATA_W];
      2'd1:    word = head[3*DATA_W-1:2*DATA_W];
      2'd2:    word = head[2*DATA_W-1:DATA_W];
      default: word = head[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= G_IDLE;
      idx      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        G_IDLE: begin
          idx <= '0;
          if (count != '0) state <= G_BUSY;
        end
        G_BUSY: begin
          if (busy_reset) begin
            state <= G_RELEASE;
          end else if (read) begin
            rd_data  <= word;
            rd_valid <= 1'b1;
            if (idx != WORD_IDX_OPCODE) idx <= idx + 1'b1;
          end
        end
        G_RELEASE: begin
          idx <= '0;
          // Go straight back to busy when a command survives the pop, so
          // busy is low for a single cycle between back-to-back commands.
          if ((count > CW'(1)) || push) state <= G_BUSY;
          else                          state <= G_IDLE;
        end
        default: state <= G_IDLE;
      endcase
    end
  end

`ifdef GPU_CMD_STATUS_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= DATA_W'({count, full, empty, busy});
  end
`else
  logic unused_status;
  assign unused_status = avs_read;
  assign avs_readdata  = '0;
`endif

endmodule

// File: tb/tb_gpu_cmd_slave.sv
// Scoreboard bench for gpu_cmd_slave: reads push expected words into a queue,
// a forked monitor pops and compares whenever rd_valid is seen.
module tb_gpu_cmd_slave;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        busy;
  logic        read = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy_reset = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  gpu_cmd_slave #(.CMD_DEPTH(4), .DATA_W(32)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .avs_address     (avs_address),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_read        (avs_read),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .busy            (busy),
    .read            (read),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .busy_reset      (busy_reset)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    while (avs_waitrequest && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("host_wr_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic wr_cmd(input logic [31:0] a, b, c, opc);
    host_wr(2'd0, a); host_wr(2'd1, b); host_wr(2'd2, c); host_wr(2'd3, opc);
  endtask

  task automatic gpu_rd(input logic [31:0] exp);
    read = 1'b1; sb.push_back(exp);
    tick();
    read = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    check("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic retire();
    busy_reset = 1'b1; tick(); busy_reset = 1'b0;
  endtask

  task automatic status_rd(input logic [31:0] exp);
    avs_read = 1'b1; tick(); avs_read = 1'b0;
    check("avs_readdata", avs_readdata, exp);
  endtask

  logic [31:0] cmds [4][4];

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rd_valid) begin
          if (sb.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else check("rd_data", rd_data, sb.pop_front());
        end
      end
    join_none

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_waitreq", 32'(avs_waitrequest), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    n_reset = 1'b1;
    tick();
`ifdef GPU_CMD_STATUS_EN
    status_rd(32'b010);
`else
    status_rd(32'd0);
`endif

    // Basic command, latency, word order, saturation, read vs busy_reset
    wr_cmd(32'h11, 32'h22, 32'h33, 32'hA5);
    check("busy_lat1", 32'(busy), 32'd0);
    tick();
    check("busy_lat2", 32'(busy), 32'd1);
    gpu_rd(32'h11); gpu_rd(32'h22); gpu_rd(32'h33); gpu_rd(32'hA5);
    gpu_rd(32'hA5);
    read = 1'b1; busy_reset = 1'b1; tick(); read = 1'b0; busy_reset = 1'b0;
    check("rd_vs_reset_valid", 32'(rd_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    tick(); tick();
    check("empty_idle_busy", 32'(busy), 32'd0);
`ifndef GPU_CMD_STATUS_EN
    status_rd(32'd0);
`endif

    // Two queued commands: busy drops for exactly one cycle
    wr_cmd(32'h1, 32'h2, 32'h3, 32'hB1);
    wr_cmd(32'h4, 32'h5, 32'h6, 32'hB2);
    wait_busy();
    gpu_rd(32'h1);
    retire();
    check("b2b_gap", 32'(busy), 32'd0);
    tick();
    check("b2b_rearm", 32'(busy), 32'd1);
    gpu_rd(32'h4);
    retire();
    tick(); tick();

    // Full FIFO stalls a fifth commit until the head is released
    for (int i = 0; i < 4; i++) begin
      cmds[i][0] = 32'h100 + 32'(i*16) + 1;
      cmds[i][1] = 32'h100 + 32'(i*16) + 2;
      cmds[i][2] = 32'h100 + 32'(i*16) + 3;
      cmds[i][3] = 32'hC0 + 32'(i);
      wr_cmd(cmds[i][0], cmds[i][1], cmds[i][2], cmds[i][3]);
    end
    avs_address = 2'd3; avs_writedata = 32'hE5; avs_write = 1'b1;
    #1 check("full_stall0", 32'(avs_waitrequest), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("full_stall", 32'(avs_waitrequest), 32'd1);
    end
    busy_reset = 1'b1; tick(); busy_reset = 1'b0;
    check("stall_release", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0;
    check("full_rearm", 32'(busy), 32'd1);
    // Remaining: cmds 1..3 then the stalled one, built from unchanged staging
    for (int c = 1; c < 5; c++) begin
      wait_busy();
      for (int w = 0; w < 4; w++)
        gpu_rd((c == 4) ? ((w == 3) ? 32'hE5 : cmds[3][w]) : cmds[c][w]);
      retire();
    end
    tick(); tick();
    check("drained_busy", 32'(busy), 32'd0);

    // Async reset in the middle of a drain with a stalled commit pending
    for (int i = 0; i < 4; i++)
      wr_cmd(32'h50 + 32'(i), 32'h60, 32'h70, 32'hD0);
    wait_busy();
    avs_address = 2'd3; avs_writedata = 32'hEE; avs_write = 1'b1;
    #1 check("rst_pre_stall", 32'(avs_waitrequest), 32'd1);
    gpu_rd(32'h50);
    read = 1'b1; sb.push_back(32'h60);
    @(posedge clk); #1;
    read = 1'b0;
    #1 n_reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_waitreq", 32'(avs_waitrequest), 32'd0);
    sb.delete();
    avs_write = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();
`ifdef GPU_CMD_STATUS_EN
    status_rd(32'b010);
`else
    status_rd(32'd0);
`endif
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    wr_cmd(32'h77, 32'h88, 32'h99, 32'hAA);
    wait_busy();
    gpu_rd(32'h77);
    retire();
    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
